// File: rtl/mpadd_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   LW        : limb width of the shared adder slice (fixed at 6)
//   state_e   : sequencer states IDLE -> RUN -> DONE -> IDLE
//   idx_width : width of the limb index for a given limb count
package mpadd_pkg;

  localparam int LW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Enough bits to hold limb numbers 0..words-1; never narrower than 1 bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/adder6_ci.sv
// 6-bit parallel-prefix (Kogge-Stone) adder with carry-in.
//   X, Y : addends
//   ci   : carry into bit 0
//   S    : sum
//   cout : carry out of bit 5
//   c5   : carry into bit 5 (XOR with cout gives signed overflow)
module adder6_ci (
  input  logic [5:0] X,
  input  logic [5:0] Y,
  input  logic       ci,
  output logic [5:0] S,
  output logic       cout,
  output logic       c5
);

  // gk[l][i] / pk[l][i]: group generate / propagate over bits
  // [i : i-2^l+1] after prefix level l. Level 3 spans all bits down to 0.
  logic [3:0][5:0] gk;
  logic [3:0][5:0] pk;
  logic [6:0]      carry;   // carry[i] = carry into bit i

  always_comb begin
    // NOTE: every variable of this block gets a value before any branch
    // or loop, so no path can leave one unassigned and infer a latch.
    gk    = '0;
    pk    = '0;
    carry = '0;

    gk[0] = X & Y;
    pk[0] = X ^ Y;

    for (int lvl = 1; lvl < 4; lvl++) begin
      for (int i = 0; i < (1 << (lvl - 1)); i++) begin
        gk[lvl][i] = gk[lvl-1][i];
        pk[lvl][i] = pk[lvl-1][i];
      end
      for (int i = (1 << (lvl - 1)); i < 6; i++) begin
        gk[lvl][i] = gk[lvl-1][i] | (pk[lvl-1][i] & gk[lvl-1][i - (1 << (lvl - 1))]);
        pk[lvl][i] = pk[lvl-1][i] & pk[lvl-1][i - (1 << (lvl - 1))];
      end
    end

    // Fold the carry-in in last: carry into bit i+1 is the prefix over
    // [i:0] with ci treated as the generate of a virtual bit -1.
    carry[0] = ci;
    for (int i = 0; i < 6; i++) begin
      carry[i+1] = gk[3][i] | (pk[3][i] & ci);
    end
  end

  assign S    = pk[0] ^ carry[5:0];
  assign cout = carry[6];
  assign c5   = carry[5];

endmodule

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer. Latches two WORDS x LW-bit
// operands on start, walks them through one shared 6-bit adder slice one
// limb per cycle (least-significant first) with the carry chained in a
// register, then pulses done with the full-width result.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   sub        : 0 = A+B, 1 = A-B (latched with start)
//   A, B       : operands (latched with start)
//   busy       : high while running and in the done cycle
//   done       : one-cycle pulse, result valid
//   S          : result register
//   cout       : final carry-out (for subtract, 1 = no borrow)
//   ovf        : two's-complement overflow of the full-width operation
// WORDS must be at least 2; LW must stay at the slice width.
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int LW    = mpadd_pkg::LW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [LW*WORDS-1:0] A,
  input  logic [LW*WORDS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [LW*WORDS-1:0] S,
  output logic                cout,
  output logic                ovf
);

  localparam int N     = LW * WORDS;
  localparam int IDX_W = idx_width(WORDS);

  state_e           state;
  state_e           state_n;

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     s_q;
  logic             sub_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;
  logic [IDX_W-1:0] idx;
  logic             last_limb;

  logic [LW-1:0]    slice_x;
  logic [LW-1:0]    slice_y;
  logic [LW-1:0]    slice_s;
  logic             slice_co;
  logic             slice_c5;

  assign last_limb = (idx == IDX_W'(WORDS - 1));

  // Subtraction is A + ~B + 1: B is inverted per limb and the +1 enters
  // as the initial carry (c_q is loaded with sub on start).
  assign slice_x = a_q[int'(idx)*LW +: LW];
  assign slice_y = b_q[int'(idx)*LW +: LW] ^ {LW{sub_q}};

  adder6_ci u_slice (
    .X    (slice_x),
    .Y    (slice_y),
    .ci   (c_q),
    .S    (slice_s),
    .cout (slice_co),
    .c5   (slice_c5)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the values present before the edge, independent of
    // statement order across blocks.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)     state_n = RUN;
      RUN:     if (last_limb) state_n = DONE;
      DONE:                   state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Operand, index, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are reset along with the rest even though
    // they are reloaded before use; a reset mid-run then leaves no trace of
    // the aborted operation anywhere in the block.
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            sub_q <= sub;
            c_q   <= sub;
            idx   <= '0;
            // Cleared so a partly written result never mixes with the old one.
            s_q   <= '0;
          end
        end
        RUN: begin
          s_q[int'(idx)*LW +: LW] <= slice_s;
          c_q                     <= slice_co;
          if (last_limb) begin
            cout_q <= slice_co;
            ovf_q  <= slice_c5 ^ slice_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mpadd_seq.sv
// Self-checking bench for mpadd_seq (WORDS = 4, 24-bit). A cycle-level
// model computes each result with plain integer arithmetic at acceptance
// and predicts busy/done from the fixed latency; a negedge process compares
// every cycle. Directed cases pin the model with literal expectations.
module tb_mpadd_seq;

  localparam int WORDS = 4;
  localparam int N     = 24;

  typedef struct packed {
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mpadd_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: unsigned result/carry and signed range test.
  function automatic res_t model_fn(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    res_t   r;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint v;
    if (!s) begin
      r.s  = N'(ua + ub);
      r.co = ((ua + ub) >= 64'sd16777216);
      v    = sa + sb;
    end else begin
      r.s  = N'(ua - ub);
      r.co = (ua >= ub);
      v    = sa - sb;
    end
    r.ov = (v > 64'sd8388607) || (v < -64'sd8388608);
    return r;
  endfunction

  // Timeline model: cycles_left counts the busy cycles still to come;
  // the last of them (value 1) is the done cycle.
  int   cycles_left = 0;
  res_t pend        = '0;
  res_t expd        = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_left <= 0;
      expd        <= '0;
    end else if (cycles_left == 0) begin
      if (start === 1'b1) begin
        pend        <= model_fn(A, B, sub);
        expd.s      <= '0;
        cycles_left <= WORDS + 1;
      end
    end else begin
      cycles_left <= cycles_left - 1;
      if (cycles_left == 2) expd <= pend;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(cycles_left != 0));
    check("done", 32'(done), 32'(cycles_left == 1));
    if (cycles_left <= 1) begin
      check("S",    32'(S),    32'(expd.s));
      check("cout", 32'(cout), 32'(expd.co));
      check("ovf",  32'(ovf),  32'(expd.ov));
    end
  end

  // Issue one operation from idle and wait (bounded) for its done pulse.
  // poke: toggle start and scramble inputs while busy; all must be ignored.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input bit lit, input logic [N-1:0] ls, input logic lco,
                        input logic lov, input bit poke);
    int n    = 0;
    bit seen = 0;
    @(posedge clk); #1;
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (poke) begin
        start = 1'($urandom_range(0, 1));
        A     = N'($urandom);
        B     = N'($urandom);
        sub   = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (lit) begin
      check("latency",  32'(n),    32'd5);
      check("lit_S",    32'(S),    32'(ls));
      check("lit_cout", 32'(cout), 32'(lco));
      check("lit_ovf",  32'(ovf),  32'(lov));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int lastd;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_S",    32'(S),    32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    #11 rst_n = 1'b1;

    // Directed cases with hand-computed results
    run_op(24'hFFFFFF, 24'h000001, 1'b0, 1, 24'h000000, 1'b1, 1'b0, 0);
    run_op(24'h000005, 24'h000007, 1'b1, 1, 24'hFFFFFE, 1'b0, 1'b0, 1);
    run_op(24'h123456, 24'h123456, 1'b1, 1, 24'h000000, 1'b1, 1'b0, 0);
    run_op(24'h800000, 24'h000001, 1'b1, 1, 24'h7FFFFF, 1'b1, 1'b1, 0);
    run_op(24'h7FFFFF, 24'h000001, 1'b0, 1, 24'h800000, 1'b0, 1'b1, 0);

    // Hold: new operands without start leave the result untouched
    repeat (6) begin
      @(negedge clk);
      A = N'($urandom); B = N'($urandom); sub = 1'($urandom_range(0, 1));
    end
    check("hold_S",    32'(S),    32'h800000);
    check("hold_cout", 32'(cout), 32'd0);
    check("hold_ovf",  32'(ovf),  32'd1);

    // Back-to-back with start held high: one done every 6 cycles
    @(posedge clk); #1;
    A = 24'd3; B = 24'd4; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    nd = 0; lastd = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) begin
          check("b2b_first_cycle", 32'(i), 32'd5);
          check("b2b_first_S",     32'(S), 32'd7);
        end else begin
          check("b2b_interval", 32'(i - lastd), 32'd6);
        end
        lastd = i;
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(nd), 32'd3);

    // Reset during RUN at limb 2
    @(posedge clk); #1;
    A = N'($urandom); B = N'($urandom); sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_S",    32'(S),    32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_op(24'h000010, 24'h000020, 1'b0, 1, 24'h000030, 1'b0, 1'b0, 0);

    // Randomized operations with random gaps and ignored starts
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
             0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpadd_seq.md
# mpadd_seq

Multi-precision add/subtract sequencer built around one shared 6-bit carry-chained adder slice. It latches two WORDS×6-bit operands, walks them limb by limb through the slice (least-significant first), and chains the carry in a register. It returns the full-width result with carry-out and signed overflow under a start/done handshake. It sits between the register-file/control logic and the 6-bit adder datapath, and lets a narrow adder serve wide arithmetic.

## Interface

Parameters:
- WORDS, 4, number of 6-bit limbs per operand; must be ≥ 2.
- LW, 6, limb width; fixed by the datapath and not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; latched with start.
- A  input  LW·WORDS  operand A; latched with start.
- B  input  LW·WORDS  operand B; latched with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- S  output  LW·WORDS  result register.
- cout  output  1  final carry-out of the top limb. For sub, 1 means no borrow.
- ovf  output  1  two's-complement overflow of the full-width operation.

## Operation

- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE, start=1:
  - Latch A, B and sub.
  - Clear limb index idx to 0.
  - Set carry register c to sub.
  - Go to RUN.
- IDLE, start=0: hold all state. S, cout and ovf keep the last result.
- RUN, each cycle:
  - Slice inputs: a=A[idx], b=B[idx]^{LW{sub}}, ci=c.
  - The slice produces a 6-bit sum and a carry.
  - Write the sum into S[idx] and the carry into c.
  - idx increments.
- RUN, when idx = WORDS−1:
  - Write cout from the carry.
  - ovf = carry-into-MSB XOR carry-out-of-MSB, taken from the top limb.
  - Go to DONE.
- DONE: assert done for exactly one cycle, then go to IDLE.
- start while busy is ignored. There is no queuing and latched operands are unaffected.
- S is cleared to 0 on start, so partially written results are never mixed with a stale result.
- Width rules:
  - Result is modulo 2^(LW·WORDS).
  - The carry is exactly one bit between limbs.
  - idx width is clog2(WORDS) and does not wrap during a RUN.

## Timing

- Reset values:
  - state=IDLE, idx=0, c=0
  - S=0, cout=0, ovf=0
  - busy=0, done=0
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced.
- Latency: start is sampled at edge 0 → RUN occupies WORDS cycles → done high during cycle WORDS+1.
- Issue interval is WORDS+2 cycles. A start in the cycle after done is accepted.
- S, cout and ovf are stable and valid from the done cycle until the next accepted start.
- busy rises in the cycle after start is accepted and falls together with done.
- The slice path is purely combinational between registers. There is one limb per cycle and no multicycle paths.

## Structure

- Package mpadd_pkg contains:
  - localparam LW = 6
  - the state enum {IDLE, RUN, DONE}
  - a helper function for the idx width
- Sub-module adder6_ci:
  - 6-bit parallel-prefix adder with carry-in.
  - Ports: X[5:0], Y[5:0], ci → S[5:0], cout, c5.
  - c5 is the carry into bit 5 and is needed for ovf.
  - Instantiated exactly once. It is the shared resource this block sequences.
- The top level holds the FSM, operand registers, idx counter, carry register and result register.

## Test plan

All scenarios use WORDS=4 (24-bit).

- Add with full carry ripple: A=0xFFFFFF, B=0x000001, sub=0 → S=0x000000, cout=1, ovf=0; done in cycle 5 after start.
- Subtract with borrow: A=0x000005, B=0x000007, sub=1 → S=0xFFFFFE, cout=0, ovf=0.
- Signed overflow: A=0x7FFFFF, B=0x000001, sub=0 → S=0x800000, cout=0, ovf=1.
- Back-to-back with ignored start:
  - Hold start=1 continuously with A=3, B=4 → first result S=7.
  - Starts during busy are ignored; next accept happens the cycle after done.
  - Exactly one done pulse per 6 cycles.
- Reset mid-run: drop rst_n during RUN at idx=2 → all outputs are 0 immediately. No done pulse. The next start completes normally: A=0x000010, B=0x000020 → S=0x000030.
- Latency/hold check: after done, change A and B with no start → S, cout and ovf remain unchanged.
